rob_circular_buffer: RTL and testbench

//  Parametrised reorder buffer: circular queue of ROB_SIZE entries with head/tail pointers. Sits between decode, completion and commit.

---
 rtl/rob_circular_buffer_pkg.sv | 36 +++
 rtl/rob_circular_buffer_if.sv | 54 +++++
 rtl/rob_circular_buffer_entry_reg.sv | 57 +++++
 rtl/rob_circular_buffer.sv | 116 +++++++++++
 tb/tb_rob_circular_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_circular_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rob_circular_buffer_pkg                                         |
// | Purpose : Shared defaults, entry layout and helpers for the reorder       |
// |           buffer slice.                                                   |
// | Ports   : none (package)                                                  |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package rob_circular_buffer_pkg;

  localparam int unsigned ROB_SIZE_DEF = 32;
  localparam int unsigned DATA_W_DEF   = 70;
  localparam int unsigned MGMT_W_DEF   = 8;
  localparam int unsigned N_RD_DEF     = 2;
  localparam int unsigned TAG_W_DEF    = $clog2(ROB_SIZE_DEF);

  // Pointer and occupancy types for the default configuration. The count
  // carries one extra bit so that "full" and "empty" stay distinguishable.
  typedef logic [TAG_W_DEF-1:0] robPtr_t;
  typedef logic [TAG_W_DEF:0]   robCount_t;

  // One reorder-buffer entry in the default configuration.
  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [MGMT_W_DEF-1:0] mgmt;
    logic [DATA_W_DEF-1:0] data;
  } rob_entry_t;

  // True when n is a power of two; the pointer wrap relies on this.
  function automatic bit isPow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_circular_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rob_circular_buffer_if                                          |
// | Purpose : Decode/completion/commit bundle of the reorder buffer.          |
// | Ports   : flush, alloc (valid/ready/data/tag), completion (en/tag/data),  |
// |           N_RD read ports (tag/data/ready), commit (valid/ready/data/tag), |
// |           count and empty status.                                         |
// |           master = pipeline side, slave = reorder buffer.                 |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface rob_circular_buffer_if
  import rob_circular_buffer_pkg::*;
#(
  parameter int unsigned ROB_SIZE = ROB_SIZE_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MGMT_W   = MGMT_W_DEF,
  parameter int unsigned N_RD     = N_RD_DEF
);
  localparam int unsigned TAG_W = $clog2(ROB_SIZE);

  logic                     flush_i;
  logic                     alloc_valid_i;
  logic                     alloc_ready_o;
  logic [MGMT_W-1:0]        alloc_data_i;
  logic [TAG_W-1:0]         alloc_tag_o;
  logic                     cmpl_en_i;
  logic [TAG_W-1:0]         cmpl_tag_i;
  logic [DATA_W-1:0]        cmpl_data_i;
  logic [N_RD*TAG_W-1:0]    rd_tag_i;
  logic [N_RD*DATA_W-1:0]   rd_data_o;
  logic [N_RD-1:0]          rd_ready_o;
  logic                     commit_valid_o;
  logic                     commit_ready_i;
  logic [MGMT_W+DATA_W-1:0] commit_data_o;
  logic [TAG_W-1:0]         commit_tag_o;
  logic [TAG_W:0]           count_o;
  logic                     empty_o;

  modport master (
    output flush_i, alloc_valid_i, alloc_data_i, cmpl_en_i, cmpl_tag_i,
           cmpl_data_i, rd_tag_i, commit_ready_i,
    input  alloc_ready_o, alloc_tag_o, rd_data_o, rd_ready_o, commit_valid_o,
           commit_data_o, commit_tag_o, count_o, empty_o
  );

  modport slave (
    input  flush_i, alloc_valid_i, alloc_data_i, cmpl_en_i, cmpl_tag_i,
           cmpl_data_i, rd_tag_i, commit_ready_i,
    output alloc_ready_o, alloc_tag_o, rd_data_o, rd_ready_o, commit_valid_o,
           commit_data_o, commit_tag_o, count_o, empty_o
  );

endinterface
`default_nettype wire

// File: rtl/rob_circular_buffer_entry_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rob_entry_reg                                                   |
// | Purpose : Storage for one reorder-buffer entry.                           |
// | Ports   : clk_i, reset_ni        clock, async active-low reset            |
// |           setAlloc, allocMgmt    claim entry, load management payload     |
// |           setCmpl, cmplData      mark done, load result payload           |
// |           clr                    release entry (commit or flush)          |
// |           valid, done, mgmt, data registered entry contents              |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module rob_entry_reg
  import rob_circular_buffer_pkg::*;
#(
  parameter int unsigned MGMT_W = MGMT_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  wire logic              clk_i,
  input  wire logic              reset_ni,
  input  wire logic              setAlloc,
  input  wire logic [MGMT_W-1:0] allocMgmt,
  input  wire logic              setCmpl,
  input  wire logic [DATA_W-1:0] cmplData,
  input  wire logic              clr,
  output logic                   valid,
  output logic                   done,
  output logic [MGMT_W-1:0]      mgmt,
  output logic [DATA_W-1:0]      data
);

  // clr dominates; payloads are left untouched by a release so that only
  // the valid/done flags need clearing on flush.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid <= 1'b0;
      done  <= 1'b0;
      mgmt  <= '0;
      data  <= '0;
    end else begin
      if (clr) begin
        valid <= 1'b0;
        done  <= 1'b0;
      end else if (setAlloc) begin
        valid <= 1'b1;
        done  <= 1'b0;
        mgmt  <= allocMgmt;
      end else if (setCmpl) begin
        done  <= 1'b1;
      end
      if (setCmpl && !clr) begin
        data <= cmplData;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rob_circular_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rob_circular_buffer                                             |
// | Purpose : Circular reorder buffer. Decode allocates in order, completion  |
// |           marks entries done, commit retires done entries from the head,  |
// |           read ports forward results by tag, flush empties the buffer.    |
// | Ports   : clk_i     clock                                                 |
// |           reset_ni  async active-low reset                                |
// |           bus       rob_circular_buffer_if.slave (all handshakes)         |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module rob_circular_buffer
  import rob_circular_buffer_pkg::*;
#(
  parameter int unsigned ROB_SIZE = ROB_SIZE_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MGMT_W   = MGMT_W_DEF,
  parameter int unsigned N_RD     = N_RD_DEF
) (
  input wire logic             clk_i,
  input wire logic             reset_ni,
  rob_circular_buffer_if.slave bus
);

  localparam int unsigned    TAG_W  = $clog2(ROB_SIZE);
  localparam logic [TAG_W:0] c_full = (TAG_W+1)'(ROB_SIZE);

  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;

  logic [ROB_SIZE-1:0] w_valid;
  logic [ROB_SIZE-1:0] w_done;
  logic [MGMT_W-1:0]   w_mgmt [ROB_SIZE];
  logic [DATA_W-1:0]   w_data [ROB_SIZE];

  logic w_allocReady;
  logic w_allocFire;
  logic w_commitValid;
  logic w_commitFire;
  logic w_cmplHit;

  // Handshake qualifiers come from registered state only, so a slot freed by
  // a commit is not offered to decode until the following cycle.
  assign w_allocReady  = (r_count != c_full);
  assign w_allocFire   = bus.alloc_valid_i & w_allocReady;
  assign w_commitValid = w_valid[r_head] & w_done[r_head];
  assign w_commitFire  = w_commitValid & bus.commit_ready_i;
  assign w_cmplHit     = bus.cmpl_en_i & w_valid[bus.cmpl_tag_i];

  assign bus.alloc_ready_o  = w_allocReady;
  assign bus.alloc_tag_o    = r_tail;
  assign bus.commit_valid_o = w_commitValid;
  assign bus.commit_tag_o   = r_head;
  assign bus.commit_data_o  = {w_mgmt[r_head], w_data[r_head]};
  assign bus.count_o        = r_count;
  assign bus.empty_o        = (r_count == '0);

  // One-hot decode of alloc/completion/commit onto the entry array. Flush
  // suppresses alloc and completion and releases every entry.
  for (genvar i = 0; i < ROB_SIZE; i++) begin : g_entry
    localparam logic [TAG_W-1:0] c_idx = TAG_W'(i);

    rob_entry_reg #(
      .MGMT_W (MGMT_W),
      .DATA_W (DATA_W)
    ) u_entry (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .setAlloc  (w_allocFire & ~bus.flush_i & (r_tail == c_idx)),
      .allocMgmt (bus.alloc_data_i),
      .setCmpl   (w_cmplHit & ~bus.flush_i & (bus.cmpl_tag_i == c_idx)),
      .cmplData  (bus.cmpl_data_i),
      .clr       (bus.flush_i | (w_commitFire & (r_head == c_idx))),
      .valid     (w_valid[i]),
      .done      (w_done[i]),
      .mgmt      (w_mgmt[i]),
      .data      (w_data[i])
    );
  end

  // Read ports forward a same-cycle completion so decode need not wait a
  // cycle for a result that is being written right now.
  for (genvar p = 0; p < N_RD; p++) begin : g_rdPort
    logic [TAG_W-1:0] w_tag;
    logic             w_bypass;

    assign w_tag    = bus.rd_tag_i[p*TAG_W +: TAG_W];
    assign w_bypass = w_cmplHit & (bus.cmpl_tag_i == w_tag);
    assign bus.rd_data_o[p*DATA_W +: DATA_W] = w_bypass ? bus.cmpl_data_i : w_data[w_tag];
    assign bus.rd_ready_o[p] = w_bypass | (w_valid[w_tag] & w_done[w_tag]);
  end

  // Pointers wrap naturally because ROB_SIZE is a power of two.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_allocFire) begin
        r_tail <= r_tail + TAG_W'(1);
      end
      if (w_commitFire) begin
        r_head <= r_head + TAG_W'(1);
      end
      r_count <= r_count + (TAG_W+1)'(w_allocFire) - (TAG_W+1)'(w_commitFire);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_circular_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_rob_circular_buffer                                          |
// | Purpose : Directed self-checking bench for rob_circular_buffer with an    |
// |           8-entry buffer.                                                 |
// | Ports   : none                                                            |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_rob_circular_buffer;

  localparam int unsigned ROB_SIZE = 8;
  localparam int unsigned DATA_W   = 70;
  localparam int unsigned MGMT_W   = 8;
  localparam int unsigned N_RD     = 2;

  logic clk_i    = 1'b0;
  logic reset_ni = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  rob_circular_buffer_if #(
    .ROB_SIZE (ROB_SIZE), .DATA_W (DATA_W), .MGMT_W (MGMT_W), .N_RD (N_RD)
  ) bus ();

  rob_circular_buffer #(
    .ROB_SIZE (ROB_SIZE), .DATA_W (DATA_W), .MGMT_W (MGMT_W), .N_RD (N_RD)
  ) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.flush_i        = 1'b0;
    bus.alloc_valid_i  = 1'b0;
    bus.alloc_data_i   = '0;
    bus.cmpl_en_i      = 1'b0;
    bus.cmpl_tag_i     = '0;
    bus.cmpl_data_i    = '0;
    bus.rd_tag_i       = '0;
    bus.commit_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    idle();
    #3;
    vectors++;
    if (bus.count_o !== 4'd0 || bus.empty_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_count: count=%0d empty=%b, want 0/1", bus.count_o, bus.empty_o);
    end
    vectors++;
    if (bus.alloc_ready_o !== 1'b1 || bus.commit_valid_o !== 1'b0 || bus.alloc_tag_o !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_hs: ready=%b cvalid=%b tag=%0d, want 1/0/0",
               bus.alloc_ready_o, bus.commit_valid_o, bus.alloc_tag_o);
    end
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      bus.alloc_valid_i = 1'b1;
      bus.alloc_data_i  = 8'(i);
      #1;
      vectors++;
      if (bus.alloc_tag_o !== 3'(i) || bus.alloc_ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_tag%0d: tag=%0d ready=%b, want %0d/1", i, bus.alloc_tag_o, bus.alloc_ready_o, i);
      end
      step();
    end
    bus.alloc_data_i = 8'h09;
    #1;
    vectors++;
    if (bus.alloc_ready_o !== 1'b0 || bus.count_o !== 4'd8) begin
      miscompares++;
      $display("FAIL fill_full: ready=%b count=%0d, want 0/8", bus.alloc_ready_o, bus.count_o);
    end
    step();
    bus.alloc_valid_i = 1'b0;
    #1;
    vectors++;
    if (bus.count_o !== 4'd8 || bus.alloc_tag_o !== 3'd0 || bus.commit_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_ninth: count=%0d tag=%0d cvalid=%b, want 8/0/0",
               bus.count_o, bus.alloc_tag_o, bus.commit_valid_o);
    end
  endtask

  task automatic test_complete_order();
    bus.cmpl_en_i   = 1'b1;
    bus.cmpl_tag_i  = 3'd3;
    bus.cmpl_data_i = 70'h30;
    #1;
    step();
    bus.cmpl_tag_i  = 3'd0;
    bus.cmpl_data_i = 70'h0;
    bus.rd_tag_i    = {3'd3, 3'd0};
    #1;
    vectors++;
    if (bus.commit_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL order_early: cvalid=%b, want 0", bus.commit_valid_o);
    end
    vectors++;
    if (bus.rd_ready_o[1] !== 1'b1 || bus.rd_data_o[2*DATA_W-1:DATA_W] !== 70'h30) begin
      miscompares++;
      $display("FAIL order_rd3: ready=%b data=%h, want 1/30", bus.rd_ready_o[1], bus.rd_data_o[2*DATA_W-1:DATA_W]);
    end
    step();
    bus.cmpl_en_i = 1'b0;
    bus.rd_tag_i  = '0;
    #1;
    vectors++;
    if (bus.commit_valid_o !== 1'b1 || bus.commit_tag_o !== 3'd0 || bus.commit_data_o !== 78'h0) begin
      miscompares++;
      $display("FAIL order_head0: cvalid=%b tag=%0d data=%h, want 1/0/0",
               bus.commit_valid_o, bus.commit_tag_o, bus.commit_data_o);
    end
  endtask

  task automatic test_full_commit_alloc();
    bus.commit_ready_i = 1'b1;
    bus.alloc_valid_i  = 1'b1;
    bus.alloc_data_i   = 8'h88;
    #1;
    vectors++;
    if (bus.alloc_ready_o !== 1'b0 || bus.commit_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL fullca_block: ready=%b cvalid=%b, want 0/1", bus.alloc_ready_o, bus.commit_valid_o);
    end
    step();
    bus.commit_ready_i = 1'b0;
    #1;
    vectors++;
    if (bus.count_o !== 4'd7 || bus.alloc_ready_o !== 1'b1 || bus.alloc_tag_o !== 3'd0) begin
      miscompares++;
      $display("FAIL fullca_free: count=%0d ready=%b tag=%0d, want 7/1/0",
               bus.count_o, bus.alloc_ready_o, bus.alloc_tag_o);
    end
    vectors++;
    if (bus.commit_tag_o !== 3'd1 || bus.commit_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fullca_stall: head=%0d cvalid=%b, want 1/0", bus.commit_tag_o, bus.commit_valid_o);
    end
    step();
    bus.alloc_valid_i = 1'b0;
    #1;
    vectors++;
    if (bus.count_o !== 4'd8 || bus.alloc_ready_o !== 1'b0 || bus.alloc_tag_o !== 3'd1) begin
      miscompares++;
      $display("FAIL fullca_wrap: count=%0d ready=%b tag=%0d, want 8/0/1",
               bus.count_o, bus.alloc_ready_o, bus.alloc_tag_o);
    end
  endtask

  task automatic test_bypass();
    bus.cmpl_en_i   = 1'b1;
    bus.cmpl_tag_i  = 3'd5;
    bus.cmpl_data_i = 70'h2_0000_0000_0000_0055;
    bus.rd_tag_i    = {3'd6, 3'd5};
    #1;
    vectors++;
    if (bus.rd_ready_o[0] !== 1'b1 || bus.rd_data_o[DATA_W-1:0] !== 70'h2_0000_0000_0000_0055) begin
      miscompares++;
      $display("FAIL bypass_same: ready=%b data=%h, want 1/20000000000000055", bus.rd_ready_o[0], bus.rd_data_o[DATA_W-1:0]);
    end
    vectors++;
    if (bus.rd_ready_o[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_other: ready=%b, want 0", bus.rd_ready_o[1]);
    end
    step();
    bus.cmpl_en_i   = 1'b0;
    bus.cmpl_data_i = '0;
    #1;
    vectors++;
    if (bus.rd_ready_o[0] !== 1'b1 || bus.rd_data_o[DATA_W-1:0] !== 70'h2_0000_0000_0000_0055) begin
      miscompares++;
      $display("FAIL bypass_stored: ready=%b data=%h, want 1/20000000000000055", bus.rd_ready_o[0], bus.rd_data_o[DATA_W-1:0]);
    end
    bus.rd_tag_i = {3'd6, 3'd0};
    #1;
    vectors++;
    if (bus.rd_ready_o[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_realloc: ready=%b, want 0", bus.rd_ready_o[0]);
    end
    bus.rd_tag_i = '0;
  endtask

  task automatic test_drain();
    bus.cmpl_en_i   = 1'b1;
    bus.cmpl_tag_i  = 3'd1;
    bus.cmpl_data_i = 70'h11;
    step();
    bus.cmpl_tag_i  = 3'd2;
    bus.cmpl_data_i = 70'h22;
    step();
    bus.cmpl_en_i = 1'b0;
    #1;
    vectors++;
    if (bus.commit_valid_o !== 1'b1 || bus.commit_data_o !== {8'd1, 70'h11}) begin
      miscompares++;
      $display("FAIL drain_h1: cvalid=%b data=%h, want 1/%h", bus.commit_valid_o, bus.commit_data_o, {8'd1, 70'h11});
    end
    bus.commit_ready_i = 1'b1;
    step();
    vectors++;
    if (bus.commit_tag_o !== 3'd2 || bus.commit_data_o !== {8'd2, 70'h22} || bus.commit_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_h2: tag=%0d data=%h cvalid=%b, want 2/%h/1",
               bus.commit_tag_o, bus.commit_data_o, bus.commit_valid_o, {8'd2, 70'h22});
    end
    step();
    vectors++;
    if (bus.commit_tag_o !== 3'd3 || bus.commit_data_o !== {8'd3, 70'h30} || bus.commit_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_h3: tag=%0d data=%h cvalid=%b, want 3/%h/1",
               bus.commit_tag_o, bus.commit_data_o, bus.commit_valid_o, {8'd3, 70'h30});
    end
    step();
    bus.commit_ready_i = 1'b0;
    #1;
    vectors++;
    if (bus.commit_tag_o !== 3'd4 || bus.commit_valid_o !== 1'b0 || bus.count_o !== 4'd5) begin
      miscompares++;
      $display("FAIL drain_h4: tag=%0d cvalid=%b count=%0d, want 4/0/5",
               bus.commit_tag_o, bus.commit_valid_o, bus.count_o);
    end
  endtask

  task automatic test_flush();
    bus.cmpl_en_i   = 1'b1;
    bus.cmpl_tag_i  = 3'd4;
    bus.cmpl_data_i = 70'h44;
    step();
    bus.flush_i        = 1'b1;
    bus.alloc_valid_i  = 1'b1;
    bus.alloc_data_i   = 8'hAA;
    bus.cmpl_tag_i     = 3'd6;
    bus.cmpl_data_i    = 70'h66;
    bus.commit_ready_i = 1'b1;
    #1;
    vectors++;
    if (bus.commit_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_pre: cvalid=%b, want 1", bus.commit_valid_o);
    end
    step();
    idle();
    bus.rd_tag_i = {3'd6, 3'd5};
    #1;
    vectors++;
    if (bus.count_o !== 4'd0 || bus.empty_o !== 1'b1 || bus.commit_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_empty: count=%0d empty=%b cvalid=%b, want 0/1/0",
               bus.count_o, bus.empty_o, bus.commit_valid_o);
    end
    vectors++;
    if (bus.commit_tag_o !== 3'd0 || bus.alloc_tag_o !== 3'd0 || bus.alloc_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_ptrs: head=%0d tail=%0d ready=%b, want 0/0/1",
               bus.commit_tag_o, bus.alloc_tag_o, bus.alloc_ready_o);
    end
    vectors++;
    if (bus.rd_ready_o !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_rd: ready=%b, want 00", bus.rd_ready_o);
    end
    bus.rd_tag_i = '0;
  endtask

  task automatic test_async_reset();
    bus.alloc_valid_i = 1'b1;
    bus.alloc_data_i  = 8'h01;
    step();
    bus.alloc_data_i  = 8'h02;
    step();
    bus.alloc_valid_i = 1'b0;
    bus.cmpl_en_i     = 1'b1;
    bus.cmpl_tag_i    = 3'd0;
    bus.cmpl_data_i   = 70'h77;
    step();
    bus.cmpl_en_i = 1'b0;
    #1;
    vectors++;
    if (bus.commit_valid_o !== 1'b1 || bus.count_o !== 4'd2) begin
      miscompares++;
      $display("FAIL arst_pre: cvalid=%b count=%0d, want 1/2", bus.commit_valid_o, bus.count_o);
    end
    #2 reset_ni = 1'b0;
    #1;
    vectors++;
    if (bus.count_o !== 4'd0 || bus.empty_o !== 1'b1 || bus.commit_valid_o !== 1'b0 ||
        bus.alloc_ready_o !== 1'b1 || bus.alloc_tag_o !== 3'd0 || bus.commit_tag_o !== 3'd0) begin
      miscompares++;
      $display("FAIL arst_now: count=%0d empty=%b cvalid=%b ready=%b tail=%0d head=%0d, want 0/1/0/1/0/0",
               bus.count_o, bus.empty_o, bus.commit_valid_o, bus.alloc_ready_o,
               bus.alloc_tag_o, bus.commit_tag_o);
    end
    #1 reset_ni = 1'b1;
    step();
    bus.cmpl_en_i   = 1'b1;
    bus.cmpl_tag_i  = 3'd2;
    bus.cmpl_data_i = 70'h5A;
    bus.rd_tag_i    = {3'd0, 3'd2};
    #1;
    vectors++;
    if (bus.rd_ready_o !== 2'b00) begin
      miscompares++;
      $display("FAIL arst_cmpl_same: ready=%b, want 00", bus.rd_ready_o);
    end
    step();
    bus.cmpl_en_i = 1'b0;
    #1;
    vectors++;
    if (bus.rd_ready_o !== 2'b00 || bus.count_o !== 4'd0) begin
      miscompares++;
      $display("FAIL arst_cmpl_next: ready=%b count=%0d, want 00/0", bus.rd_ready_o, bus.count_o);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_complete_order();
    test_full_commit_alloc();
    test_bypass();
    test_drain();
    test_flush();
    test_async_reset();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
